// File: rtl/read_iq_pkg.sv
// Globals shared by the FM radio datapath: sample widths, quantization and read_iq state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package read_iq_pkg;

    // Width of every fixed-point word flowing between datapath blocks.
    localparam int DATA_SIZE = 32;

    // Number of fractional bits applied when a raw sample enters the datapath.
    localparam int BITS = 10;

    // Width of one raw byte from the input byte FIFO.
    localparam int BYTE_SIZE = 8;

    // One I or Q component is two little-endian bytes.
    localparam int SAMPLE_WIDTH = 2 * BYTE_SIZE;

    // The quantized value must fit without saturation logic.
    localparam bit QUANT_FITS = (SAMPLE_WIDTH + BITS) <= DATA_SIZE;

    // Front-end state: gathering bytes, or holding a finished pair until both sinks accept it.
    typedef enum logic [1:0] {
        S_READ  = 2'd0,
        S_WRITE = 2'd1
    } read_iq_state_t;

    // Sign-extend a raw 16-bit component to DATA_SIZE, then scale by 2^BITS.
    function automatic logic [DATA_SIZE-1:0] quantize(input logic [SAMPLE_WIDTH-1:0] raw);
        logic [DATA_SIZE-1:0] ext;
        ext = {{(DATA_SIZE - SAMPLE_WIDTH){raw[SAMPLE_WIDTH-1]}}, raw};
        return ext << BITS;
    endfunction

endpackage

// File: rtl/read_iq.sv
// Assembles little-endian I/Q byte quadruples into quantized DATA_SIZE samples for the real/imag FIFOs.
// Latency: 1 cycle from the last byte popped to the paired write; best case 5 cycles per sample.
// Backpressure: holds the sample (and stops popping) until both output FIFOs are non-full, then writes both together.
// Optional: define READ_IQ_SAMPLE_COUNT_EN to add the 32-bit sample_count output.
module read_iq
    import read_iq_pkg::*;
#(
    parameter int BYTES_PER_SAMPLE = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [BYTE_SIZE-1:0] in_dout,
    input  logic                 in_empty,
    output logic                 in_rd_en,
    output logic [DATA_SIZE-1:0] i_out_din,
    input  logic                 i_out_full,
    output logic                 i_out_wr_en,
    output logic [DATA_SIZE-1:0] q_out_din,
    input  logic                 q_out_full,
    output logic                 q_out_wr_en
`ifdef READ_IQ_SAMPLE_COUNT_EN
    ,
    output logic [31:0]          sample_count
`endif
);

    localparam int CNT_W = $clog2(BYTES_PER_SAMPLE);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_SAMPLE - 1);

    read_iq_state_t       state;
    logic [CNT_W-1:0]     byte_cnt;
    logic [BYTE_SIZE-1:0] buffer [BYTES_PER_SAMPLE];
    logic [DATA_SIZE-1:0] i_reg;
    logic [DATA_SIZE-1:0] q_reg;
    logic                 sinks_ready;

    // Both FIFOs must have room; they are only ever written as a pair.
    assign sinks_ready = !i_out_full && !q_out_full;

    // Byte gathering and sample hand-off state machine.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_READ;
            byte_cnt <= '0;
            i_reg    <= '0;
            q_reg    <= '0;
            for (int b = 0; b < BYTES_PER_SAMPLE; b++) begin
                buffer[b] <= '0;
            end
        end else begin
            case (state)
                S_READ: begin
                    if (!in_empty) begin
                        buffer[byte_cnt] <= in_dout;
                        if (byte_cnt == LAST_BYTE) begin
                            // Q_hi is taken straight from the FIFO so the pair is ready on this edge.
                            byte_cnt <= '0;
                            i_reg    <= quantize({buffer[1], buffer[0]});
                            q_reg    <= quantize({in_dout, buffer[2]});
                            state    <= S_WRITE;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end
                end
                S_WRITE: begin
                    if (sinks_ready) begin
                        state <= S_READ;
                    end
                end
                default: begin
                    state <= S_READ;
                end
            endcase
        end
    end

    // Same-cycle FIFO strobes; forced low while reset is asserted so no byte is lost or sample pushed.
    always_comb begin
        in_rd_en    = 1'b0;
        i_out_wr_en = 1'b0;
        q_out_wr_en = 1'b0;
        if (!reset) begin
            case (state)
                S_READ: begin
                    in_rd_en = !in_empty;
                end
                S_WRITE: begin
                    i_out_wr_en = sinks_ready;
                    q_out_wr_en = sinks_ready;
                end
                default: begin
                    in_rd_en    = 1'b0;
                    i_out_wr_en = 1'b0;
                    q_out_wr_en = 1'b0;
                end
            endcase
        end
    end

    assign i_out_din = i_reg;
    assign q_out_din = q_reg;

`ifdef READ_IQ_SAMPLE_COUNT_EN
    // Count of samples delivered downstream; wraps naturally at 2^32.
    always_ff @(posedge clock) begin
        if (reset) begin
            sample_count <= '0;
        end else if (i_out_wr_en) begin
            sample_count <= sample_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_read_iq.sv
module tb_read_iq;
    import read_iq_pkg::*;

    logic        clock;
    logic        reset;
    logic [7:0]  in_dout;
    logic        in_empty;
    logic        in_rd_en;
    logic [31:0] i_out_din;
    logic        i_out_full;
    logic        i_out_wr_en;
    logic [31:0] q_out_din;
    logic        q_out_full;
    logic        q_out_wr_en;
`ifdef READ_IQ_SAMPLE_COUNT_EN
    logic [31:0] sample_count;
`endif

    int checks;
    int errors;

    read_iq dut (
        .clock       (clock),
        .reset       (reset),
        .in_dout     (in_dout),
        .in_empty    (in_empty),
        .in_rd_en    (in_rd_en),
        .i_out_din   (i_out_din),
        .i_out_full  (i_out_full),
        .i_out_wr_en (i_out_wr_en),
        .q_out_din   (q_out_din),
        .q_out_full  (q_out_full),
        .q_out_wr_en (q_out_wr_en)
`ifdef READ_IQ_SAMPLE_COUNT_EN
        ,
        .sample_count(sample_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Offer one byte after `gap` empty cycles; expects it to be popped immediately.
    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int g = 0; g < gap; g++) begin
            in_empty = 1'b1;
            @(negedge clock);
            checks++;
            if (in_rd_en !== 1'b0) begin
                errors++;
                $display("FAIL gap_rd_en: got %b want 0", in_rd_en);
            end
            @(posedge clock); #1;
        end
        in_empty = 1'b0;
        in_dout  = b;
        @(negedge clock);
        checks++;
        if (in_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL byte_rd_en: got %b want 1 (byte %h)", in_rd_en, b);
        end
        @(posedge clock); #1;
        in_empty = 1'b1;
    endtask

    // Wait (bounded) for the paired write and compare the sample against the expected words.
    task automatic expect_write(input string name, input logic [31:0] exp_i, input logic [31:0] exp_q);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clock);
            if (i_out_wr_en === 1'b1 || q_out_wr_en === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (i_out_wr_en !== 1'b1 || q_out_wr_en !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_pair: i_wr=%b q_wr=%b want both 1", name, i_out_wr_en, q_out_wr_en);
                end
                checks++;
                if (i_out_din !== exp_i) begin
                    errors++;
                    $display("FAIL %s_i: got %h want %h", name, i_out_din, exp_i);
                end
                checks++;
                if (q_out_din !== exp_q) begin
                    errors++;
                    $display("FAIL %s_q: got %h want %h", name, q_out_din, exp_q);
                end
            end
            @(posedge clock); #1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no write within 20 cycles", name);
        end
        // Exactly one write per assembled sample.
        @(negedge clock);
        checks++;
        if (i_out_wr_en !== 1'b0 || q_out_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL %s_single: i_wr=%b q_wr=%b want 0 0", name, i_out_wr_en, q_out_wr_en);
        end
        @(posedge clock); #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        in_empty   = 1'b0;
        in_dout    = 8'h5A;
        i_out_full = 1'b0;
        q_out_full = 1'b0;
        reset      = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if (in_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_rd_en: got %b want 0", in_rd_en);
        end
        checks++;
        if (i_out_wr_en !== 1'b0 || q_out_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_wr_en: got %b %b want 0 0", i_out_wr_en, q_out_wr_en);
        end
        checks++;
        if (i_out_din !== 32'h0 || q_out_din !== 32'h0) begin
            errors++;
            $display("FAIL reset_din: got %h %h want 0 0", i_out_din, q_out_din);
        end
`ifdef READ_IQ_SAMPLE_COUNT_EN
        checks++;
        if (sample_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_count: got %0d want 0", sample_count);
        end
`endif
        @(posedge clock); #1;
        in_empty = 1'b1;
        reset    = 1'b0;
    endtask

    task automatic test_basic();
        send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'hFF, 0); send_byte(8'hFF, 0);
        expect_write("basic1", 32'h0000_0400, 32'hFFFF_FC00);
        send_byte(8'hFF, 0); send_byte(8'h7F, 0); send_byte(8'h00, 0); send_byte(8'h80, 0);
        expect_write("basic2", 32'h01FF_FC00, 32'hFE00_0000);
    endtask

    task automatic test_backpressure();
        send_byte(8'h05, 0); send_byte(8'h00, 0); send_byte(8'h06, 0);
        q_out_full = 1'b1;
        send_byte(8'h00, 0);
        // A byte is available throughout the stall; it must not be popped.
        in_empty = 1'b0;
        in_dout  = 8'hAA;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            checks++;
            if (in_rd_en !== 1'b0 || i_out_wr_en !== 1'b0 || q_out_wr_en !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d rd=%b i_wr=%b q_wr=%b want 0 0 0",
                         c, in_rd_en, i_out_wr_en, q_out_wr_en);
            end
            @(posedge clock); #1;
        end
        q_out_full = 1'b0;
        in_empty   = 1'b1;
        @(negedge clock);
        checks++;
        if (i_out_wr_en !== 1'b1 || q_out_wr_en !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: i_wr=%b q_wr=%b want 1 1", i_out_wr_en, q_out_wr_en);
        end
        checks++;
        if (i_out_din !== 32'h0000_1400 || q_out_din !== 32'h0000_1800) begin
            errors++;
            $display("FAIL bp_data: got %h %h want 00001400 00001800", i_out_din, q_out_din);
        end
        @(posedge clock); #1;
        @(negedge clock);
        checks++;
        if (i_out_wr_en !== 1'b0 || q_out_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL bp_single: i_wr=%b q_wr=%b want 0 0", i_out_wr_en, q_out_wr_en);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_gaps();
        send_byte(8'h02, 3); send_byte(8'h00, 3); send_byte(8'h03, 3); send_byte(8'h00, 3);
        expect_write("gaps", 32'h0000_0800, 32'h0000_0C00);
    endtask

    task automatic test_reset_mid();
        send_byte(8'h33, 0); send_byte(8'h44, 0);
        apply_reset();
        send_byte(8'h04, 0); send_byte(8'h00, 0); send_byte(8'hFE, 0); send_byte(8'hFF, 0);
        expect_write("rst_mid", 32'h0000_1000, 32'hFFFF_F800);
    endtask

    task automatic test_back_to_back();
        logic [7:0]  stim [400];
        logic [15:0] iv, qv;
        logic [31:0] exp_i, exp_q;
        int bi, writes, last_cyc, spacing_bad, data_bad;
        for (int k = 0; k < 100; k++) begin
            iv = 16'(k * 3 + 1);
            qv = 16'(-(k + 1) * 7);
            stim[4*k]   = iv[7:0];
            stim[4*k+1] = iv[15:8];
            stim[4*k+2] = qv[7:0];
            stim[4*k+3] = qv[15:8];
        end
        apply_reset();
        bi = 0; writes = 0; last_cyc = 0; spacing_bad = 0; data_bad = 0;
        for (int cyc = 0; cyc < 700 && writes < 100; cyc++) begin
            in_empty = (bi >= 400);
            in_dout  = (bi < 400) ? stim[bi] : 8'h00;
            @(negedge clock);
            if (i_out_wr_en === 1'b1) begin
                iv    = 16'(writes * 3 + 1);
                qv    = 16'(-(writes + 1) * 7);
                exp_i = {{6{iv[15]}}, iv, 10'b0};
                exp_q = {{6{qv[15]}}, qv, 10'b0};
                if (i_out_din !== exp_i || q_out_din !== exp_q || q_out_wr_en !== 1'b1) begin
                    data_bad++;
                    if (data_bad < 4)
                        $display("FAIL b2b_data: sample %0d got %h %h want %h %h",
                                 writes, i_out_din, q_out_din, exp_i, exp_q);
                end
                if (cyc - last_cyc != (writes == 0 ? 4 : 5)) begin
                    spacing_bad++;
                    if (spacing_bad < 4)
                        $display("FAIL b2b_spacing: sample %0d gap %0d cycles", writes, cyc - last_cyc);
                end
                last_cyc = cyc;
                writes++;
            end
            if (in_rd_en === 1'b1) bi++;
            @(posedge clock); #1;
        end
        in_empty = 1'b1;
        checks++;
        if (writes != 100) begin
            errors++;
            $display("FAIL b2b_writes: got %0d want 100", writes);
        end
        checks++;
        if (data_bad != 0) begin
            errors++;
            $display("FAIL b2b_data_total: got %0d bad samples want 0", data_bad);
        end
        checks++;
        if (spacing_bad != 0) begin
            errors++;
            $display("FAIL b2b_spacing_total: got %0d bad gaps want 0", spacing_bad);
        end
`ifdef READ_IQ_SAMPLE_COUNT_EN
        @(negedge clock);
        checks++;
        if (sample_count !== 32'd100) begin
            errors++;
            $display("FAIL b2b_count: got %0d want 100", sample_count);
        end
        @(posedge clock); #1;
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset      = 1'b1;
        in_empty   = 1'b1;
        in_dout    = 8'h00;
        i_out_full = 1'b0;
        q_out_full = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
